handshaking_slave_fifo: RTL
===========================

# handshaking_slave_fifo

Parametrised successor to the single-register handshake slave: a valid/ready receiver that buffers up to DEPTH words of DATA_WIDTH bits in a first-word-fall-through FIFO. It presents a matching valid/ready source interface to the downstream consumer. It also reports occupancy and a sticky upstream protocol-violation flag. It sits between a handshaking master (producer) and any consumer that may stall for several cycles.

## Interface
Parameters:
- DATA_WIDTH, 8, payload width in bits (≥1)
- DEPTH, 4, buffer entries; power of two, ≥2
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- data_in  input  DATA_WIDTH  upstream payload
- data_valid  input  1  upstream word available
- data_ready  output  1  slave can accept; high only when not full and rst low
- data_out  output  DATA_WIDTH  head-of-FIFO payload
- out_valid  output  1  FIFO non-empty
- ready  input  1  downstream consumer accepts data_out
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- protocol_err  output  1  sticky upstream handshake violation

## Operation
- Push on rising clk when data_valid && data_ready: mem[wr_ptr] <= data_in, wr_ptr++.
- Pop on rising clk when out_valid && ready: rd_ptr++.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- count: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- Status FSM (registered), next state from count_next:
  - EMPTY (count=0): out_valid=0, data_ready=1.
  - PARTIAL (0<count<DEPTH): out_valid=1, data_ready=1.
  - FULL (count=DEPTH): out_valid=1, data_ready=0.
- Legal transitions:
  - EMPTY→PARTIAL on push.
  - PARTIAL→EMPTY on pop with count=1 and no push.
  - PARTIAL→FULL on push with count=DEPTH−1 and no pop.
  - FULL→PARTIAL on pop.
- DEPTH=2 still passes through PARTIAL.
- data_out = mem[rd_ptr], first-word fall-through. It is stable while out_valid && !ready.
- Full boundary:
  - data_ready depends only on registered state. In FULL no push occurs even if a pop happens in the same cycle.
  - data_ready rises the cycle after the pop.
- Empty boundary:
  - Push only; ready is ignored while out_valid=0.
  - The pushed word is not forwarded combinationally.
- Simultaneous push+pop in PARTIAL: both occur, count and state unchanged.
- protocol_err:
  - Set when, on a clock edge, the previous cycle had data_valid=1 && data_ready=0 and now either data_valid=0 or data_in differs from its value in that previous cycle.
  - Requires a registered copy of data_valid, data_ready and data_in.
  - Cleared only by rst.
- Reset (async, asserted any time, including mid-transfer):
  - Pointers=0, count=0, state=EMPTY, all mem entries=0, protocol_err=0, internal copies cleared.
  - Buffered data is discarded.
  - While rst=1: data_ready=0, out_valid=0, data_out=0, count=0.

## Timing
- All outputs except data_out derive from registers; data_out is a mux on rd_ptr.
- Latency data_in→data_out: 1 cycle. A word pushed at edge N shows out_valid=1 and data_out=word after edge N.
- Throughput: 1 word/cycle sustained when both sides are always ready.
- After rst deasserts, data_ready=1 from the first following cycle. The first push is possible at the first rising edge with rst low.
- The protocol_err set is visible the cycle after the offending edge.

## Test plan
- Reset check: assert rst mid-stream with 3 words buffered. Required: count=0, out_valid=0, data_out=0, data_ready=0 during rst, then data_ready=1 after release.
- Single word, DATA_WIDTH=8: push 8'hD4 with ready=0. Required: next cycle out_valid=1, data_out=8'hD4, count=1. Raise ready; after one edge out_valid=0, count=0.
- Fill/full, DEPTH=4: push 8'h01..8'h04 with ready=0. Required: count=4, data_ready=0. Hold data_valid=1 with 8'h05; it is not accepted. Then pop 4 words in order 01,02,03,04 and data_ready returns after the first pop.
- Simultaneous push+pop with count=2 over 10 cycles. Required: count stays 2, data_out sequence is in FIFO order, and pointers wrap past DEPTH without loss.
- Protocol violation: fill to FULL, hold data_valid=1 with data_in=8'hAA, then change to 8'hAB while still stalled. Required: protocol_err=1 the next cycle and it stays set until rst.
- Parameter sweep at DATA_WIDTH=16, DEPTH=8: random valid/ready for 500 cycles against a scoreboard. Required: no loss or duplication, count matches the model, and out_valid=0 iff count=0.

Source files
------------

// File: rtl/handshaking_slave_fifo.sv
// Valid/ready slave backed by a first-word-fall-through FIFO. It reports occupancy and a sticky
// flag for upstream handshake violations.
module handshaking_slave_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_valid,
   input  logic                  ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  protocol_err
);

   localparam logic [ADDR_WIDTH-1:0] PtrOne    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   CountOne  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH:0]   FullCount = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  push, pop;
   logic                  prev_valid_q, prev_ready_q;
   logic [DATA_WIDTH-1:0] prev_data_q;
   logic                  err_q, err_d;

   // Handshake outputs come only from the registered state, so a pop while full
   // reopens data_ready one cycle later rather than in the same cycle.
   always_comb begin
      data_ready = 1'b0;
      out_valid  = 1'b0;
      unique case (state_q)
         StEmpty:   data_ready = ~rst;
         StPartial: begin
            data_ready = ~rst;
            out_valid  = 1'b1;
         end
         StFull:    out_valid = 1'b1;
         default:   ;
      endcase

      push = data_valid & data_ready;
      pop  = out_valid & ready;

      case ({push, pop})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase

      if (count_d == '0) begin
         state_d = StEmpty;
      end else if (count_d == FullCount) begin
         state_d = StFull;
      end else begin
         state_d = StPartial;
      end

      // A stalled word must be held stable until it is accepted.
      err_d = err_q | (prev_valid_q & ~prev_ready_q &
                       (~data_valid | (data_in != prev_data_q)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StEmpty;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         prev_valid_q <= 1'b0;
         prev_ready_q <= 1'b0;
         prev_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (push) begin
            mem_q[wr_ptr_q] <= data_in;
            wr_ptr_q        <= wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
         end
         prev_valid_q <= data_valid;
         prev_ready_q <= data_ready;
         prev_data_q  <= data_in;
         err_q        <= err_d;
      end
   end

   assign data_out     = mem_q[rd_ptr_q];
   assign count        = count_q;
   assign protocol_err = err_q;

endmodule
